// File: rtl/shift_rx_pkg.sv
// Shared types and line-level constants for the serial receiver.
package shift_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP
  } rx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/shift_rx8b_if.sv
// Serial line, word handshake and status signals of the receiver.
interface shift_rx8b_if #(
    parameter int unsigned DATA_W = 8
);
    logic              s_in;
    logic              bit_en;
    logic              out_ready;
    logic [DATA_W-1:0] p_out;
    logic              out_valid;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    modport master (
        output s_in, bit_en, out_ready,
        input  p_out, out_valid, frame_err, overrun, busy
    );

    modport slave (
        input  s_in, bit_en, out_ready,
        output p_out, out_valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/shift_in_reg.sv
// Serial-in shift register with enable; direction selects where new bits enter.
module shift_in_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (en) begin
            // LSB-first lines enter at the MSB so the first bit ends up in bit 0
            if (LSB_FIRST) begin
                q_q <= {d, q_q[WIDTH-1:1]};
            end else begin
                q_q <= {q_q[WIDTH-2:0], d};
            end
        end
    end

    assign q = q_q;

endmodule

// File: rtl/shift_rx8b.sv
// Framed serial receiver: start/data/stop FSM feeding a held output word with
// valid/ready handoff, frame error pulse and sticky overrun.
module shift_rx8b
    import shift_rx_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input logic         clk,
    input logic         rst,
    shift_rx8b_if.slave rx
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] p_out_q, p_out_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              shift_en;
    logic              word_done;

    shift_in_reg #(
        .WIDTH     (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .clk (clk),
        .rst (rst),
        .en  (shift_en),
        .d   (rx.s_in),
        .q   (shreg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            p_out_q     <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_out_q     <= p_out_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_en    = 1'b0;
        word_done   = 1'b0;
        frame_err_d = 1'b0;
        if (rx.bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (rx.s_in == START_BIT) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    // A bad stop bit returns to IDLE; it is never reused as a start bit
                    state_d = IDLE;
                    if (rx.s_in == STOP_BIT) begin
                        word_done = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        p_out_d     = p_out_q;
        out_valid_d = out_valid_q & ~rx.out_ready;
        overrun_d   = overrun_q;
        if (word_done) begin
            p_out_d     = shreg;
            out_valid_d = 1'b1;
            if (out_valid_q && !rx.out_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rx.p_out     = p_out_q;
    assign rx.out_valid = out_valid_q;
    assign rx.frame_err = frame_err_q;
    assign rx.overrun   = overrun_q;
    assign rx.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_rx8b.sv
// Directed bench for shift_rx8b: LSB-first default instance plus an MSB-first instance.
module tb_shift_rx8b;

    logic clk;
    logic rst;
    logic s_in;
    logic bit_en;
    logic out_ready;
    int   checks;
    int   errors;

    shift_rx8b_if #(.DATA_W(8)) bus ();
    shift_rx8b_if #(.DATA_W(8)) bus2 ();

    assign bus.s_in       = s_in;
    assign bus.bit_en     = bit_en;
    assign bus.out_ready  = out_ready;
    assign bus2.s_in      = s_in;
    assign bus2.bit_en    = bit_en;
    assign bus2.out_ready = out_ready;

    shift_rx8b #(.DATA_W(8), .LSB_FIRST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus)
    );

    shift_rx8b #(.DATA_W(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk (clk),
        .rst (rst),
        .rx  (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic line_bit(input logic b);
        s_in   = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] w, input logic stop_bit,
                              input logic ready_at_stop, input logic msb_first);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            line_bit(msb_first ? w[7-i] : w[i]);
        end
        out_ready = ready_at_stop;
        line_bit(stop_bit);
        out_ready = 1'b0;
        s_in      = 1'b1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        s_in      = 1'b1;
        bit_en    = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        s_in      = 1'b1;
        bit_en    = 1'b0;
        out_ready = 1'b0;
        #3;
        checks++;
        if (bus.p_out !== 8'h00) begin
            errors++; $display("FAIL reset_p_out: got %h expected 00", bus.p_out);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err);
        end
        checks++;
        if (bus.overrun !== 1'b0) begin
            errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        line_bit(1'b0);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy_after_start: got %b expected 1", bus.busy);
        end
        for (int i = 0; i < 8; i++) line_bit(i[0] ? 1'b0 : 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_valid_early: got %b expected 0", bus.out_valid);
        end
        line_bit(1'b1);
        checks++;
        if (bus.p_out !== 8'h55) begin
            errors++; $display("FAIL basic_p_out: got %h expected 55", bus.p_out);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_ferr: got %b/%b expected 1/0", bus.out_valid,
                     bus.frame_err);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_accept: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_frame_err();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.frame_err !== 1'b1) begin
            errors++; $display("FAIL ferr_pulse: got %b expected 1", bus.frame_err);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.p_out !== 8'h55) begin
            errors++;
            $display("FAIL ferr_word_kept: got %b/%h expected 0/55", bus.out_valid, bus.p_out);
        end
        line_bit(1'b1);
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++; $display("FAIL ferr_one_cycle: got %b expected 0", bus.frame_err);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL ferr_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_overrun();
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.p_out !== 8'hA3 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: got %h/%b expected a3/0", bus.p_out, bus.overrun);
        end
        send_frame(8'h5C, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.p_out !== 8'h5C) begin
            errors++; $display("FAIL ovr_p_out: got %h expected 5c", bus.p_out);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_flags: got %b/%b expected 1/1", bus.out_valid, bus.overrun);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: got %b/%b expected 0/1", bus.out_valid, bus.overrun);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.p_out !== 8'h12 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got %h/%b expected 12/1", bus.p_out, bus.out_valid);
        end
        send_frame(8'h34, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.p_out !== 8'h34) begin
            errors++; $display("FAIL b2b_p_out: got %h expected 34", bus.p_out);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_flags: got %b/%b expected 1/0", bus.out_valid, bus.overrun);
        end
    endtask

    task automatic test_slow_bit_en();
        logic [7:0] w;
        logic       b;
        logic       fe_seen;
        int         nclk;
        w       = 8'h3C;
        fe_seen = 1'b0;
        nclk    = 0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            b = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : w[k-1];
            for (int g = 0; g < 3; g++) begin
                // Opposite level on the gap edges would corrupt the word if sampled
                s_in   = ~b;
                bit_en = 1'b0;
                @(posedge clk);
                #1;
                nclk++;
                fe_seen = fe_seen | bus.frame_err;
                if (k == 5 && g == 1) begin
                    checks++;
                    if (bus.busy !== 1'b1) begin
                        errors++; $display("FAIL slow_busy_gap: got %b expected 1", bus.busy);
                    end
                end
            end
            line_bit(b);
            nclk++;
            fe_seen = fe_seen | bus.frame_err;
        end
        s_in = 1'b1;
        checks++;
        if (bus.p_out !== 8'h3C || nclk != 40) begin
            errors++;
            $display("FAIL slow_p_out: got %h after %0d clocks expected 3c after 40", bus.p_out,
                     nclk);
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL slow_valid: got %b expected 1", bus.out_valid);
        end
        checks++;
        if (fe_seen !== 1'b0) begin
            errors++; $display("FAIL slow_no_ferr: got %b expected 0", fe_seen);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        line_bit(1'b0);
        for (int i = 0; i < 4; i++) line_bit(1'b1);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL midrst_busy_before: got %b expected 1", bus.busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL midrst_async_busy: got %b expected 0", bus.busy);
        end
        rst  = 1'b0;
        s_in = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.p_out !== 8'hF0) begin
            errors++; $display("FAIL midrst_p_out: got %h expected f0", bus.p_out);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL midrst_flags: got %b/%b/%b expected 1/0/0", bus.out_valid,
                     bus.frame_err, bus.overrun);
        end
    endtask

    task automatic test_msb_first();
        do_reset();
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus2.p_out !== 8'h81) begin
            errors++; $display("FAIL msb_p_out: got %h expected 81", bus2.p_out);
        end
        checks++;
        if (bus2.out_valid !== 1'b1) begin
            errors++; $display("FAIL msb_valid: got %b expected 1", bus2.out_valid);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (bus2.out_valid !== 1'b0) begin
            errors++; $display("FAIL msb_accept: got %b expected 0", bus2.out_valid);
        end
        // Asymmetric word distinguishes bit order
        send_frame(8'hC4, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus2.p_out !== 8'hC4) begin
            errors++; $display("FAIL msb_order: got %h expected c4", bus2.p_out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_slow_bit_en();
        test_reset_mid_frame();
        test_msb_first();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
